// File: rtl/seg7_pkg.sv
// Shared 7-segment constants so the scan encoder and the readback decoder use one glyph table.
package seg7_pkg;

  localparam int unsigned DIGITS      = 4;
  localparam logic [3:0]  ANODE_BLANK = 4'hF;

  // Active-low g..a patterns, indexed by the hex value they display.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic single_low(input logic [3:0] an);
    logic [3:0] low;
    low = ~an;
    return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational reverse lookup of an active-low cathode pattern to its hex code.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       match,
  output logic [3:0] code
);

  always_comb begin
    match = 1'b0;
    code  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == GLYPH[i]) begin
        match = 1'b1;
        code  = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_readback.sv
// Rebuilds the four displayed digits from a sampled active-low anode/cathode scan.
module seg7_scan_readback
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE  = 3,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [3:0]  an,
  input  logic [7:0]  cat,
  output logic [15:0] dig,
  output logic [3:0]  dig_ok,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        err,
  output logic        stale
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST      = TW'(TIMEOUT - 1);
  localparam logic [3:0]    SETTLE_MAX  = 4'(SETTLE);
  localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [11:0]   SYNC_BLANK  = {ANODE_BLANK, 8'hFF};

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [11:0]   sync1, s, p;
  logic [0:0]    state;
  logic [3:0]    cnt;
  logic [3:0]    seen;
  logic [TW-1:0] tcnt;

  logic [3:0] s_an;
  logic [7:0] s_cat;
  logic [3:0] low;
  logic [1:0] idx;
  logic       change, fire, one_low, multi_low;
  logic       g_match;
  logic [3:0] g_code;
  logic [3:0] seen_next;

  assign s_an  = s[11:8];
  assign s_cat = s[7:0];
  assign low   = ~s_an;

  seg7_glyph_decode u_decode (
    .seg   (s_cat[6:0]),
    .match (g_match),
    .code  (g_code)
  );

  always_comb begin
    change    = (s != p);
    fire      = (state == ST_WAIT) && !change && (cnt == SETTLE_LAST);
    one_low   = single_low(s_an);
    multi_low = (low != 4'h0) && !one_low;
    seen_next = seen | low;
    idx       = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (low[i]) idx = 2'(i);
    end
  end

  assign stale = (tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (rest) begin
      sync1       <= SYNC_BLANK;
      s           <= SYNC_BLANK;
      p           <= SYNC_BLANK;
      state       <= ST_WAIT;
      cnt         <= '0;
      seen        <= '0;
      tcnt        <= '0;
      dig         <= '0;
      dig_ok      <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      sync1       <= {an, cat};
      s           <= sync1;
      p           <= s;
      frame_valid <= 1'b0;
      err         <= 1'b0;

      case (state)
        ST_WAIT: begin
          if (change) cnt <= '0;
          else if (cnt != SETTLE_MAX) cnt <= cnt + 4'h1;
          if (fire) state <= ST_HOLD;
        end
        default: begin
          if (change) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
      endcase

      if (fire && multi_low) err <= 1'b1;

      // A completed frame clears seen on the capture edge, so frame_valid lines up with the last digit.
      if (fire && one_low) begin
        dig[{idx, 2'b00} +: 4] <= g_code;
        dig_ok[idx]            <= g_match;
        dp[idx]                <= ~s_cat[7];
        tcnt                   <= '0;
        if (seen_next == 4'hF) begin
          seen        <= '0;
          frame_valid <= 1'b1;
        end else begin
          seen <= seen_next;
        end
      end else if (tcnt != T_LAST) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_readback.sv
// Directed bench for the 7-segment scan readback with hand-computed expectations.
module tb_seg7_scan_readback;

  logic        clk = 1'b0;
  logic        rest;
  logic [3:0]  an;
  logic [7:0]  cat;
  logic [15:0] dig;
  logic [3:0]  dig_ok;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        err;
  logic        stale;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;
  int unsigned fv_cnt   = 0;
  int unsigned err_cnt  = 0;

  seg7_scan_readback #(
    .SETTLE  (3),
    .TIMEOUT (4096)
  ) dut (
    .clk         (clk),
    .rest        (rest),
    .an          (an),
    .cat         (cat),
    .dig         (dig),
    .dig_ok      (dig_ok),
    .dp          (dp),
    .frame_valid (frame_valid),
    .err         (err),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rest = 1'b1; an = 4'hF; cat = 8'hFF;
    tick(3);
    rest = 1'b0;
    fv_cnt = 0; err_cnt = 0;
    tick(20);
    total++; if (dig !== 16'h0) $display("FAIL reset_dig got=%h want=%h", dig, 16'h0); else pass_cnt++;
    total++; if (dig_ok !== 4'h0) $display("FAIL reset_dig_ok got=%h want=%h", dig_ok, 4'h0); else pass_cnt++;
    total++; if (dp !== 4'h0) $display("FAIL reset_dp got=%h want=%h", dp, 4'h0); else pass_cnt++;
    total++; if (frame_valid !== 1'b0) $display("FAIL reset_fv got=%b want=0", frame_valid); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err); else pass_cnt++;
    total++; if (stale !== 1'b0) $display("FAIL reset_stale got=%b want=0", stale); else pass_cnt++;
    total++; if (err_cnt != 0) $display("FAIL reset_err_pulses got=%0d want=0", err_cnt); else pass_cnt++;
    total++; if (fv_cnt != 0) $display("FAIL reset_fv_pulses got=%0d want=0", fv_cnt); else pass_cnt++;
  endtask

  task automatic test_scan();
    logic [3:0] an_tab  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] cat_tab [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    int unsigned f0 = fv_cnt;
    an = an_tab[0]; cat = cat_tab[0];
    tick(5);
    total++; if (dig_ok[0] !== 1'b0) $display("FAIL scan_first_early got=%b want=0", dig_ok[0]); else pass_cnt++;
    tick(1);
    total++; if (dig_ok[0] !== 1'b1) $display("FAIL scan_first_latency got=%b want=1", dig_ok[0]); else pass_cnt++;
    tick(4);
    for (int j = 1; j < 4; j++) begin
      an = an_tab[j]; cat = cat_tab[j];
      if (j == 3) begin
        tick(5);
        total++; if (frame_valid !== 1'b0) $display("FAIL scan_fv_early got=%b want=0", frame_valid); else pass_cnt++;
        tick(1);
        total++; if (frame_valid !== 1'b1) $display("FAIL scan_fv got=%b want=1", frame_valid); else pass_cnt++;
        total++; if (dig !== 16'h3210) $display("FAIL scan_dig got=%h want=%h", dig, 16'h3210); else pass_cnt++;
        total++; if (dig_ok !== 4'hF) $display("FAIL scan_dig_ok got=%h want=%h", dig_ok, 4'hF); else pass_cnt++;
        total++; if (dp !== 4'h0) $display("FAIL scan_dp got=%h want=%h", dp, 4'h0); else pass_cnt++;
        tick(4);
      end else begin
        tick(10);
      end
    end
    tick(2);
    total++; if (fv_cnt - f0 != 1) $display("FAIL scan_fv_count got=%0d want=1", fv_cnt - f0); else pass_cnt++;
  endtask

  task automatic test_dp_unknown();
    an = 4'hE; cat = 8'h40;
    tick(10);
    total++; if (dp[0] !== 1'b1) $display("FAIL dp_lit got=%b want=1", dp[0]); else pass_cnt++;
    total++; if (dig_ok[0] !== 1'b1) $display("FAIL dp_glyph_ok got=%b want=1", dig_ok[0]); else pass_cnt++;
    cat = 8'h79;
    tick(10);
    total++; if (dig !== 16'h3211) $display("FAIL dp_dig_one got=%h want=%h", dig, 16'h3211); else pass_cnt++;
    total++; if (dp !== 4'h1) $display("FAIL dp_one got=%h want=%h", dp, 4'h1); else pass_cnt++;
    cat = 8'hFF;
    tick(10);
    total++; if (dig !== 16'h3210) $display("FAIL unknown_dig got=%h want=%h", dig, 16'h3210); else pass_cnt++;
    total++; if (dig_ok !== 4'hE) $display("FAIL unknown_ok got=%h want=%h", dig_ok, 4'hE); else pass_cnt++;
    total++; if (dp !== 4'h0) $display("FAIL unknown_dp got=%h want=%h", dp, 4'h0); else pass_cnt++;
  endtask

  task automatic test_multi_anode();
    int unsigned e0 = err_cnt;
    int unsigned f0 = fv_cnt;
    an = 4'hC; cat = 8'hF9;
    tick(10);
    an = 4'hF; cat = 8'hFF;
    tick(8);
    total++; if (err_cnt - e0 != 1) $display("FAIL multi_err_pulses got=%0d want=1", err_cnt - e0); else pass_cnt++;
    total++; if (dig !== 16'h3210) $display("FAIL multi_dig got=%h want=%h", dig, 16'h3210); else pass_cnt++;
    total++; if (dig_ok !== 4'hE) $display("FAIL multi_ok got=%h want=%h", dig_ok, 4'hE); else pass_cnt++;
    total++; if (fv_cnt != f0) $display("FAIL multi_fv got=%0d want=%0d", fv_cnt, f0); else pass_cnt++;
  endtask

  task automatic test_change_wins();
    an = 4'hE; cat = 8'hF8;
    tick(3);
    an = 4'hF; cat = 8'hFF;
    tick(10);
    total++; if (dig[3:0] !== 4'h0) $display("FAIL short_hold_dig got=%h want=0", dig[3:0]); else pass_cnt++;
    total++; if (dig_ok[0] !== 1'b0) $display("FAIL short_hold_ok got=%b want=0", dig_ok[0]); else pass_cnt++;
    an = 4'hE; cat = 8'hF8;
    tick(4);
    an = 4'hF; cat = 8'hFF;
    tick(10);
    total++; if (dig[3:0] !== 4'h7) $display("FAIL min_hold_dig got=%h want=7", dig[3:0]); else pass_cnt++;
    total++; if (dig_ok[0] !== 1'b1) $display("FAIL min_hold_ok got=%b want=1", dig_ok[0]); else pass_cnt++;
  endtask

  task automatic test_stale();
    int unsigned n = 0;
    logic found = 1'b0;
    an = 4'hE; cat = 8'h92;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1);
      if (dig[3:0] === 4'h5) found = 1'b1;
    end
    total++; if (!found) $display("FAIL stale_setup_capture got=%h want=5", dig[3:0]); else pass_cnt++;
    found = 1'b0;
    while (n < 5000 && !found) begin
      tick(1);
      n++;
      if (stale === 1'b1) found = 1'b1;
      else if (n % 2 == 1) cat = ((n / 2) % 2 == 1) ? 8'hA4 : 8'hB0;
    end
    total++; if (!found) $display("FAIL stale_timeout got=%b want=1", stale); else pass_cnt++;
    total++; if (n != 4095) $display("FAIL stale_cycles got=%0d want=4095", n); else pass_cnt++;
    total++; if (dig[3:0] !== 4'h5) $display("FAIL stale_dig_hold got=%h want=5", dig[3:0]); else pass_cnt++;
    total++; if (dig_ok[0] !== 1'b1) $display("FAIL stale_ok_hold got=%b want=1", dig_ok[0]); else pass_cnt++;
    cat = 8'h90;
    tick(10);
    total++; if (stale !== 1'b0) $display("FAIL stale_clear got=%b want=0", stale); else pass_cnt++;
    total++; if (dig[3:0] !== 4'h9) $display("FAIL stale_recapture got=%h want=9", dig[3:0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int unsigned f0;
    an = 4'hD; cat = 8'hF9;
    tick(10);
    an = 4'hB; cat = 8'hA4;
    tick(3);
    rest = 1'b1;
    tick(1);
    rest = 1'b0;
    total++; if (dig !== 16'h0) $display("FAIL midrst_dig got=%h want=%h", dig, 16'h0); else pass_cnt++;
    total++; if (dig_ok !== 4'h0) $display("FAIL midrst_ok got=%h want=%h", dig_ok, 4'h0); else pass_cnt++;
    f0 = fv_cnt;
    tick(10);
    an = 4'h7; cat = 8'hB0;
    tick(10);
    an = 4'hF; cat = 8'hFF;
    tick(4);
    total++; if (fv_cnt != f0) $display("FAIL midrst_no_frame got=%0d want=%0d", fv_cnt, f0); else pass_cnt++;
    an = 4'hE; cat = 8'hC0;
    tick(10);
    an = 4'hD; cat = 8'hF9;
    tick(10);
    total++; if (fv_cnt - f0 != 1) $display("FAIL midrst_frame got=%0d want=1", fv_cnt - f0); else pass_cnt++;
    total++; if (dig !== 16'h3210) $display("FAIL midrst_dig_final got=%h want=%h", dig, 16'h3210); else pass_cnt++;
  endtask

  initial begin
    rest = 1'b1; an = 4'hF; cat = 8'hFF;
    test_reset();
    test_scan();
    test_dp_unknown();
    test_multi_anode();
    test_change_wins();
    test_stale();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
